// File: rtl/chess_pkg.sv
// Shared chess encodings: piece codes, colours, start position,
// controller FSM states and the board nibble-index helper.
package chess_pkg;

   localparam logic [2:0] P_NONE   = 3'b000;
   localparam logic [2:0] P_PAWN   = 3'b001;
   localparam logic [2:0] P_KNIGHT = 3'b010;
   localparam logic [2:0] P_BISHOP = 3'b011;
   localparam logic [2:0] P_ROOK   = 3'b100;
   localparam logic [2:0] P_QUEEN  = 3'b101;
   localparam logic [2:0] P_KING   = 3'b110;

   localparam logic C_WHITE = 1'b0;
   localparam logic C_BLACK = 1'b1;

   // Square 0 is the rightmost hex digit; rows 7..0 left to right.
   localparam logic [255:0] INIT_BOARD = {
      32'h42365324, 32'h11111111,
      32'h00000000, 32'h00000000,
      32'h00000000, 32'h00000000,
      32'h99999999, 32'hCABEDBAC
   };

   localparam logic [5:0] CURSOR_RST = 6'b110_100;

   localparam int B_UP     = 0;
   localparam int B_DOWN   = 1;
   localparam int B_LEFT   = 2;
   localparam int B_RIGHT  = 3;
   localparam int B_CENTER = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEL    = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   function automatic int nib_lsb(input int idx);
      return idx * 4;
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for the five debounced buttons.
// The history register updates every cycle, whatever the FSM does.
module btn_edge (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] btn_i,
   output logic [4:0] rise_o
);

   logic [4:0] hist_q;
   logic [4:0] hist_d;

   always_comb begin
      hist_d = btn_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign rise_o = btn_i & ~hist_q;

endmodule

// File: rtl/board_controller.sv
// Holds the board, moves the cursor and runs select/commit.
// Every output comes straight from a register.
module board_controller
   import chess_pkg::*;
(
   input  logic         CLK,
   input  logic         RESET,
   input  logic         BTN_UP,
   input  logic         BTN_DOWN,
   input  logic         BTN_LEFT,
   input  logic         BTN_RIGHT,
   input  logic         BTN_CENTER,
   output logic [255:0] BOARD,
   output logic [5:0]   CURSOR_ADDR,
   output logic [5:0]   SELECT_ADDR,
   output logic         SELECT_EN,
   output logic         TURN,
   output logic         MOVE_DONE,
   output logic [3:0]   CAPTURED
);

   logic [4:0] rise;
   logic [3:0] board_q [64];
   logic [3:0] board_d [64];
   logic [5:0] cursor_q, cursor_d;
   logic [5:0] sel_addr_q, sel_addr_d;
   logic       sel_en_q, sel_en_d;
   logic       turn_q, turn_d;
   logic       move_done_q, move_done_d;
   logic [3:0] captured_q, captured_d;
   state_t     state_q, state_d;
   logic [3:0] cur_pc;
   logic       own_pc;

   btn_edge u_edge (
      .clk    (CLK),
      .rst_n  (RESET),
      .btn_i  ({BTN_CENTER, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP}),
      .rise_o (rise)
   );

   assign cur_pc = board_q[cursor_q];
   assign own_pc = (cur_pc[2:0] != P_NONE) && (cur_pc[3] == turn_q);

   always_comb begin
      board_d     = board_q;
      cursor_d    = cursor_q;
      sel_addr_d  = sel_addr_q;
      sel_en_d    = sel_en_q;
      turn_d      = turn_q;
      move_done_d = 1'b0;
      captured_d  = captured_q;
      state_d     = state_q;
      unique case (state_q)
         S_IDLE, S_SEL: begin
            if (rise[B_CENTER]) begin
               if (state_q == S_IDLE) begin
                  if (own_pc) begin
                     sel_addr_d = cursor_q;
                     sel_en_d   = 1'b1;
                     state_d    = S_SEL;
                  end
               end else if (cursor_q == sel_addr_q) begin
                  sel_en_d = 1'b0;
                  state_d  = S_IDLE;
               end else if (own_pc) begin
                  sel_addr_d = cursor_q;
               end else begin
                  state_d = S_COMMIT;
               end
            end else if (rise[B_UP]) begin
               if (cursor_q[5:3] != 3'd0)
                  cursor_d[5:3] = cursor_q[5:3] - 3'd1;
            end else if (rise[B_DOWN]) begin
               if (cursor_q[5:3] != 3'd7)
                  cursor_d[5:3] = cursor_q[5:3] + 3'd1;
            end else if (rise[B_LEFT]) begin
               if (cursor_q[2:0] != 3'd0)
                  cursor_d[2:0] = cursor_q[2:0] - 3'd1;
            end else if (rise[B_RIGHT]) begin
               if (cursor_q[2:0] != 3'd7)
                  cursor_d[2:0] = cursor_q[2:0] + 3'd1;
            end
         end
         S_COMMIT: begin
            // Cursor is frozen here, so it is still the destination.
            board_d[cursor_q]   = board_q[sel_addr_q];
            board_d[sel_addr_q] = 4'd0;
            captured_d          = cur_pc;
            sel_en_d            = 1'b0;
            turn_d              = ~turn_q;
            move_done_d         = 1'b1;
            state_d             = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < 64; i++)
            board_q[i] <= INIT_BOARD[nib_lsb(i) +: 4];
         cursor_q    <= CURSOR_RST;
         sel_addr_q  <= '0;
         sel_en_q    <= 1'b0;
         turn_q      <= 1'b0;
         move_done_q <= 1'b0;
         captured_q  <= '0;
         state_q     <= S_IDLE;
      end else begin
         board_q     <= board_d;
         cursor_q    <= cursor_d;
         sel_addr_q  <= sel_addr_d;
         sel_en_q    <= sel_en_d;
         turn_q      <= turn_d;
         move_done_q <= move_done_d;
         captured_q  <= captured_d;
         state_q     <= state_d;
      end
   end

   for (genvar g = 0; g < 64; g++) begin : g_flat
      assign BOARD[nib_lsb(g) +: 4] = board_q[g];
   end

   assign CURSOR_ADDR = cursor_q;
   assign SELECT_ADDR = sel_addr_q;
   assign SELECT_EN   = sel_en_q;
   assign TURN        = turn_q;
   assign MOVE_DONE   = move_done_q;
   assign CAPTURED    = captured_q;

endmodule

// File: tb/tb_board_controller.sv
// Directed bench for board_controller: cursor, select, commit,
// capture, priority and asynchronous reset.
module tb_board_controller;

   localparam logic [4:0] K_UP = 5'b00001;
   localparam logic [4:0] K_DN = 5'b00010;
   localparam logic [4:0] K_LF = 5'b00100;
   localparam logic [4:0] K_RT = 5'b01000;
   localparam logic [4:0] K_C  = 5'b10000;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [4:0]   btn;
   logic [255:0] BOARD;
   logic [5:0]   CURSOR_ADDR;
   logic [5:0]   SELECT_ADDR;
   logic         SELECT_EN;
   logic         TURN;
   logic         MOVE_DONE;
   logic [3:0]   CAPTURED;

   int checks = 0;
   int errors = 0;
   logic [255:0] exp_init;
   logic [255:0] exp_b;

   board_controller dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .BTN_UP      (btn[0]),
      .BTN_DOWN    (btn[1]),
      .BTN_LEFT    (btn[2]),
      .BTN_RIGHT   (btn[3]),
      .BTN_CENTER  (btn[4]),
      .BOARD       (BOARD),
      .CURSOR_ADDR (CURSOR_ADDR),
      .SELECT_ADDR (SELECT_ADDR),
      .SELECT_EN   (SELECT_EN),
      .TURN        (TURN),
      .MOVE_DONE   (MOVE_DONE),
      .CAPTURED    (CAPTURED)
   );

   always #5 CLK = ~CLK;

   function automatic logic [255:0] start_pos();
      logic [255:0] b;
      int back [8];
      b = '0;
      back = '{4, 2, 3, 5, 6, 3, 2, 4};
      for (int c = 0; c < 8; c++) begin
         b[c*4 +: 4]      = {1'b1, 3'(back[c])};
         b[(8+c)*4 +: 4]  = 4'b1001;
         b[(48+c)*4 +: 4] = 4'b0001;
         b[(56+c)*4 +: 4] = {1'b0, 3'(back[c])};
      end
      return b;
   endfunction

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic press(input logic [4:0] m);
      btn = m;
      tick();
      btn = '0;
      tick();
   endtask

   task automatic press_n(input logic [4:0] m, input int n);
      for (int k = 0; k < n; k++) press(m);
   endtask

   initial begin
      exp_init = start_pos();
      exp_b    = exp_init;
      RESET = 1'b0;
      btn   = '0;
      repeat (2) tick();
      chk("board_in_reset", BOARD, exp_init);
      RESET = 1'b1;
      tick();
      chk("rst_board", BOARD, exp_init);
      chk("rst_cursor", CURSOR_ADDR, 6'd52);
      chk("rst_sel_en", SELECT_EN, 1'b0);
      chk("rst_sel_addr", SELECT_ADDR, 6'd0);
      chk("rst_turn", TURN, 1'b0);
      chk("rst_move_done", MOVE_DONE, 1'b0);
      chk("rst_captured", CAPTURED, 4'd0);

      // walk up to the black pawn on 12; wrong colour
      press_n(K_UP, 5);
      chk("cursor_12", CURSOR_ADDR, 6'd12);
      press(K_C);
      chk("wrong_colour_no_sel", SELECT_EN, 1'b0);
      press_n(K_UP, 2);
      chk("up7_clamp", CURSOR_ADDR, 6'b000_100);
      press(K_UP);
      chk("up8_hold", CURSOR_ADDR, 6'b000_100);
      btn = K_RT;
      repeat (20) tick();
      btn = '0;
      tick();
      chk("right_held", CURSOR_ADDR, 6'd5);
      press_n(K_LF, 6);
      chk("left_clamp", CURSOR_ADDR, 6'd0);
      press_n(K_DN, 8);
      chk("down_clamp", CURSOR_ADDR, 6'd56);
      press_n(K_RT, 8);
      chk("right_clamp", CURSOR_ADDR, 6'd63);
      chk("board_untouched", BOARD, exp_init);

      RESET = 1'b0;
      tick();
      RESET = 1'b1;
      tick();
      chk("rst2_cursor", CURSOR_ADDR, 6'd52);

      // select, reselect, deselect, select again
      press(K_C);
      chk("sel_en", SELECT_EN, 1'b1);
      chk("sel_addr_52", SELECT_ADDR, 6'd52);
      press(K_LF);
      press(K_C);
      chk("resel_addr_51", SELECT_ADDR, 6'd51);
      chk("resel_en", SELECT_EN, 1'b1);
      press(K_C);
      chk("desel_en", SELECT_EN, 1'b0);
      press(K_RT);
      press(K_C);
      chk("sel_again_52", SELECT_ADDR, 6'd52);
      press_n(K_UP, 2);
      chk("cursor_36", CURSOR_ADDR, 6'd36);
      chk("board_before_commit", BOARD, exp_b);
      press(K_C);
      exp_b[36*4 +: 4] = 4'b0001;
      exp_b[52*4 +: 4] = 4'b0000;
      chk("move_done_hi", MOVE_DONE, 1'b1);
      chk("nib36", BOARD[36*4 +: 4], 4'b0001);
      chk("nib52", BOARD[52*4 +: 4], 4'b0000);
      chk("board_move1", BOARD, exp_b);
      chk("turn_black", TURN, 1'b1);
      chk("captured_empty", CAPTURED, 4'd0);
      chk("sel_cleared", SELECT_EN, 1'b0);
      tick();
      chk("move_done_lo", MOVE_DONE, 1'b0);

      // black pawn 12 captures white pawn 51, UP pressed in COMMIT
      press_n(K_UP, 3);
      press(K_C);
      chk("black_sel", SELECT_ADDR, 6'd12);
      press_n(K_DN, 5);
      press(K_LF);
      chk("cursor_51", CURSOR_ADDR, 6'd51);
      btn = K_C;
      tick();
      chk("md_before_commit", MOVE_DONE, 1'b0);
      btn = K_UP;
      tick();
      exp_b[51*4 +: 4] = 4'b1001;
      exp_b[12*4 +: 4] = 4'b0000;
      chk("md_capture", MOVE_DONE, 1'b1);
      chk("captured_pawn", CAPTURED, 4'b0001);
      chk("board_capture", BOARD, exp_b);
      chk("turn_white", TURN, 1'b0);
      chk("commit_edge_drop", CURSOR_ADDR, 6'd51);
      tick();
      chk("held_no_fire", CURSOR_ADDR, 6'd51);
      chk("md_pulse_end", MOVE_DONE, 1'b0);
      btn = '0;
      tick();

      // centre beats directions, then direction priority
      press(K_DN);
      chk("cursor_59", CURSOR_ADDR, 6'd59);
      btn = K_UP | K_LF | K_C;
      tick();
      chk("prio_sel_en", SELECT_EN, 1'b1);
      chk("prio_sel_addr", SELECT_ADDR, 6'd59);
      chk("prio_cursor", CURSOR_ADDR, 6'd59);
      btn = '0;
      tick();
      press(K_UP | K_DN | K_LF | K_RT);
      chk("prio_up", CURSOR_ADDR, 6'd51);
      press(K_LF | K_RT);
      chk("prio_left", CURSOR_ADDR, 6'd50);
      press(K_C);
      chk("resel_50", SELECT_ADDR, 6'd50);
      chk("board_no_change", BOARD, exp_b);

      // asynchronous reset while in SEL
      #2;
      RESET = 1'b0;
      #1;
      chk("async_sel_en", SELECT_EN, 1'b0);
      chk("async_board", BOARD, exp_init);
      chk("async_cursor", CURSOR_ADDR, 6'd52);
      tick();
      RESET = 1'b1;
      tick();
      chk("post_rst_turn", TURN, 1'b0);
      press(K_C);
      chk("post_rst_sel", SELECT_ADDR, 6'd52);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
